// File: rtl/input_capture_pkg.sv
// Shared types and constants for the input-capture slice.
package hwag_capture_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_t;

   localparam int unsigned CAP_WIDTH   = 24;
   localparam int unsigned SYNC_STAGES = 2;

   typedef struct packed {
      logic [CAP_WIDTH-1:0] stamp;
      logic [CAP_WIDTH-1:0] period;
      logic                 first;
      logic                 sat;
   } cap_rec_t;

endpackage

// File: rtl/input_capture_sync_edge_filter.sv
// Synchronizer, run-length glitch filter and registered edge pulses for one
// asynchronous input.
module sync_edge_filter
   import hwag_capture_pkg::*;
#(
   parameter int unsigned FILTER = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic level,
   output logic rise_p,
   output logic fall_p
);

   localparam int unsigned FW = $clog2(FILTER + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [FW-1:0]          run;
   logic                   samp;

   assign samp = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= '0;
         run    <= '0;
         level  <= 1'b0;
         rise_p <= 1'b0;
         fall_p <= 1'b0;
      end else if (!en) begin
         sync   <= '0;
         run    <= '0;
         level  <= 1'b0;
         rise_p <= 1'b0;
         fall_p <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], din};
         rise_p <= 1'b0;
         fall_p <= 1'b0;
         // run counts consecutive samples that disagree with the accepted level
         if (samp != level) begin
            if (run == FW'(FILTER - 1)) begin
               level  <= samp;
               rise_p <= samp;
               fall_p <= !samp;
               run    <= '0;
            end else begin
               run <= run + 1'b1;
            end
         end else begin
            run <= '0;
         end
      end
   end

endmodule

// File: rtl/input_capture.sv
// Timestamps and period-measures filtered edges of cap_in against a
// free-running timer; records leave through a one-entry buffer.
module input_capture
   import hwag_capture_pkg::*;
#(
   parameter int unsigned WIDTH  = 24,
   parameter int unsigned FILTER = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       edge_sel,
   input  logic             cap_in,
   output logic [WIDTH-1:0] stamp_out,
   output logic [WIDTH-1:0] period_out,
   output logic             first,
   output logic             sat,
   output logic             cap_valid,
   input  logic             cap_ready,
   output logic             overrun,
   input  logic             ovr_clr
);

   typedef struct packed {
      logic [WIDTH-1:0] stamp;
      logic [WIDTH-1:0] period;
      logic             first;
      logic             sat;
   } rec_t;

   localparam logic [WIDTH-1:0] MAXV = '1;

   logic             lvl, rise_p, fall_p;
   logic [WIDTH-1:0] timer, cnt;
   logic             armed;
   edge_sel_t        sel;
   logic             want_rise, want_fall, det, load;
   rec_t             nxt, rec;

   sync_edge_filter #(.FILTER(FILTER)) u_filt (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .din    (cap_in),
      .level  (lvl),
      .rise_p (rise_p),
      .fall_p (fall_p)
   );

   assign sel       = edge_sel_t'(edge_sel);
   assign want_rise = (sel == EDGE_RISE) || (sel == EDGE_BOTH);
   assign want_fall = (sel == EDGE_FALL) || (sel == EDGE_BOTH);
   assign det       = en && ((rise_p && lvl && want_rise) || (fall_p && !lvl && want_fall));
   assign load      = det && (!cap_valid || cap_ready);

   always_comb begin
      nxt        = '0;
      nxt.stamp  = timer;
      nxt.period = armed ? '0 : cnt;
      nxt.first  = armed;
      nxt.sat    = !armed && (cnt == MAXV);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer     <= '0;
         cnt       <= '0;
         armed     <= 1'b1;
         rec       <= '0;
         cap_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (en) begin
            timer <= timer + 1'b1;
            if (det) begin
               cnt   <= WIDTH'(1);
               armed <= 1'b0;
            end else if (cnt != MAXV) begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            timer <= '0;
            cnt   <= '0;
            armed <= 1'b1;
         end

         if (load) begin
            rec       <= nxt;
            cap_valid <= 1'b1;
         end else if (cap_ready) begin
            cap_valid <= 1'b0;
         end

         if (det && cap_valid && !cap_ready)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
      end
   end

   assign stamp_out  = rec.stamp;
   assign period_out = rec.period;
   assign first      = rec.first;
   assign sat        = rec.sat;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture: two widths driven in parallel, a
// cycle-level reference model and hand-computed spot checks.
module tb_input_capture;

   localparam int F = 3;

   logic clk = 1'b0;
   logic rst, en, cap_in, cap_ready, ovr_clr;
   logic [1:0] edge_sel;

   logic [23:0] s24, p24;
   logic        f24, sat24, v24, o24;
   logic [7:0]  s8, p8;
   logic        f8, sat8, v8, o8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_capture #(.WIDTH(24), .FILTER(F)) dut24 (
      .clk(clk), .rst(rst), .en(en), .edge_sel(edge_sel), .cap_in(cap_in),
      .stamp_out(s24), .period_out(p24), .first(f24), .sat(sat24),
      .cap_valid(v24), .cap_ready(cap_ready), .overrun(o24), .ovr_clr(ovr_clr)
   );

   input_capture #(.WIDTH(8), .FILTER(F)) dut8 (
      .clk(clk), .rst(rst), .en(en), .edge_sel(edge_sel), .cap_in(cap_in),
      .stamp_out(s8), .period_out(p8), .first(f8), .sat(sat8),
      .cap_valid(v8), .cap_ready(cap_ready), .overrun(o8), .ovr_clr(ovr_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint maxv(input int w);
      return (longint'(1) << w) - 1;
   endfunction

   // Reference model: edges are judged from the history of sampled inputs.
   bit     q_raw[$];
   bit     q_f[$];
   bit     m_level, m_flip, m_flip_rise, m_armed, m_valid, m_ovr;
   longint m_tmr, m_since;
   longint r_stamp, r_period;
   bit     r_first;

   initial begin
      m_level = 0; m_flip = 0; m_flip_rise = 0; m_armed = 1;
      m_valid = 0; m_ovr = 0; m_tmr = 0; m_since = 0;
      r_stamp = 0; r_period = 0; r_first = 0;
   end

   always @(posedge clk) begin
      bit det, load, drop, x, all_new;
      if (rst) begin
         q_raw.delete(); q_f.delete();
         m_level = 0; m_flip = 0; m_armed = 1; m_valid = 0; m_ovr = 0;
         m_tmr = 0; m_since = 0; r_stamp = 0; r_period = 0; r_first = 0;
      end else begin
         det  = en && m_flip && (m_flip_rise ? edge_sel[0] : edge_sel[1]);
         load = det && (!m_valid || cap_ready);
         drop = det && m_valid && !cap_ready;
         if (load) begin
            m_valid  = 1;
            r_stamp  = m_tmr;
            r_period = m_armed ? 0 : m_since;
            r_first  = m_armed;
         end else if (cap_ready) begin
            m_valid = 0;
         end
         if (drop) m_ovr = 1;
         else if (ovr_clr) m_ovr = 0;

         if (en) begin
            if (det) begin
               m_since = 1;
               m_armed = 0;
            end else begin
               m_since++;
            end
            m_tmr++;
            x = (q_raw.size() >= 2) ? q_raw[q_raw.size() - 2] : 1'b0;
            q_raw.push_back(cap_in);
            if (q_raw.size() > 2) void'(q_raw.pop_front());
            q_f.push_back(x);
            if (q_f.size() > F) void'(q_f.pop_front());
            m_flip  = 0;
            all_new = (q_f.size() >= F);
            for (int j = 0; j < F; j++)
               if (all_new && q_f[q_f.size() - 1 - j] == m_level) all_new = 0;
            if (all_new) begin
               m_level     = !m_level;
               m_flip      = 1;
               m_flip_rise = m_level;
            end
         end else begin
            m_tmr = 0; m_since = 0; m_armed = 1; m_level = 0; m_flip = 0;
            q_raw.delete(); q_f.delete();
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_valid24", v24, m_valid);
         chk("m_valid8", v8, m_valid);
         chk("m_ovr24", o24, m_ovr);
         chk("m_ovr8", o8, m_ovr);
         if (m_valid) begin
            chk("m_stamp24", s24, r_stamp & maxv(24));
            chk("m_stamp8", s8, r_stamp & maxv(8));
            chk("m_period24", p24, r_first ? 0 : (r_period > maxv(24) ? maxv(24) : r_period));
            chk("m_period8", p8, r_first ? 0 : (r_period > maxv(8) ? maxv(8) : r_period));
            chk("m_first24", f24, r_first);
            chk("m_first8", f8, r_first);
            chk("m_sat24", sat24, !r_first && r_period >= maxv(24));
            chk("m_sat8", sat8, !r_first && r_period >= maxv(8));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cyc_cnt(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (v24) c++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c1, c2;
      logic [23:0] hs, hp;
      logic [7:0]  prev8, d8;

      rst = 1; en = 0; cap_in = 0; edge_sel = 2'b01; cap_ready = 1; ovr_clr = 0;
      cyc(3);
      chk("rst_valid", v24, 0);
      chk("rst_stamp", s24, 0);
      chk("rst_period", p24, 0);
      chk("rst_first", f24, 0);
      chk("rst_ovr", o24, 0);
      rst = 0;
      cyc(2);
      en = 1;
      cyc(10);

      // rising edges 100 cycles apart
      cap_in = 1; cyc(5);
      chk("lat_not_yet", v24, 0);
      cyc(1);
      chk("lat_valid", v24, 1);
      chk("first_flag", f24, 1);
      chk("first_period", p24, 0);
      chk("first_stamp", s24, 15);
      cyc(1);
      chk("valid_drop", v24, 0);
      cyc(43); cap_in = 0; cyc(50);
      cap_in = 1; cyc(6);
      chk("period100", p24, 100);
      chk("stamp2", s24, 115);
      chk("first2", f24, 0);
      cyc(10); cap_in = 0; cyc(10);

      // glitches shorter than the filter, then one just long enough
      c2 = 0;
      for (int i = 0; i < 3; i++) begin
         cap_in = 1; cyc_cnt(2, c1); c2 += c1;
         cap_in = 0; cyc_cnt(4, c1); c2 += c1;
      end
      cyc_cnt(8, c1); c2 += c1;
      chk("glitch_none", c2, 0);
      cap_in = 1; cyc_cnt(3, c1);
      cap_in = 0; cyc_cnt(12, c2);
      chk("pulse3_one", c1 + c2, 1);

      // 8-bit width saturates and wraps
      cyc(20);
      cap_in = 1; cyc(6);
      prev8 = s8;
      cyc(144); cap_in = 0; cyc(150);
      cap_in = 1; cyc(6);
      chk("sat_p8", p8, 255);
      chk("sat_f8", sat8, 1);
      d8 = s8 - prev8;
      chk("wrap_diff8", d8, 44);
      chk("p24_300", p24, 300);
      chk("sat24_clear", sat24, 0);
      cyc(2);

      // overrun with consumer stalled
      cap_ready = 0;
      cyc(10); cap_in = 0; cyc(10);
      cap_in = 1; cyc(6);
      chk("ovr_hold_valid", v24, 1);
      chk("ovr_none_yet", o24, 0);
      hs = s24; hp = p24;
      cyc(4); cap_in = 0; cyc(10);
      cap_in = 1; cyc(6);
      chk("ovr_set", o24, 1);
      chk("ovr_stamp_kept", s24, hs);
      chk("ovr_period_kept", p24, hp);
      ovr_clr = 1; cyc(1); ovr_clr = 0;
      chk("ovr_clr_alone", o24, 0);
      cap_in = 0; cyc(10);
      cap_in = 1; cyc(5);
      ovr_clr = 1; cyc(1); ovr_clr = 0;
      chk("ovr_set_wins", o24, 1);
      cap_ready = 1; cyc(2);
      chk("drained", v24, 0);
      ovr_clr = 1; cyc(1); ovr_clr = 0;
      chk("ovr_cleared", o24, 0);

      // both edges, acceptance coincident with each new detection
      edge_sel = 2'b11; cap_ready = 0;
      cyc(10);
      for (int i = 0; i < 6; i++) begin
         cap_in = !cap_in; cyc(5);
         cap_ready = 1; cyc(1); cap_ready = 0;
         if (i > 0) chk("both_period20", p24, 20);
         chk("both_no_ovr", o24, 0);
         chk("both_valid", v24, 1);
         for (int j = 0; j < 14; j++) begin
            cyc(1);
            chk("both_no_gap", v24, 1);
         end
      end
      cap_ready = 1; cyc(2);

      // enable dropped and raised re-arms the first flag
      edge_sel = 2'b01; cap_in = 0; cyc(10);
      en = 0; cyc(5);
      en = 1; cyc(5);
      cap_ready = 0;
      cap_in = 1; cyc(6);
      chk("en_first", f24, 1);
      chk("en_period", p24, 0);
      chk("en_stamp", s24, 10);
      cyc(3);
      chk("pending", v24, 1);

      // asynchronous reset while a record is pending
      @(posedge clk); #2 rst = 1;
      #1;
      chk("arst_valid24", v24, 0);
      chk("arst_valid8", v8, 0);
      chk("arst_stamp", s24, 0);
      chk("arst_period", p24, 0);
      chk("arst_first", f24, 0);
      chk("arst_ovr", o24, 0);
      cyc(2); rst = 0; cap_ready = 1;
      cyc(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
